// File: rtl/hex_disp_pkg.sv
// Shared types, segment table and decode helpers for hex_display_scanner.
// Segment bit order is {a,b,c,d,e,f,g}, active-high.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1111110, // 0
        7'b0110000, // 1
        7'b1101101, // 2
        7'b1111001, // 3
        7'b0110011, // 4
        7'b1011011, // 5
        7'b1011111, // 6
        7'b1110000, // 7
        7'b1111111, // 8
        7'b1111011, // 9
        7'b1110111, // A
        7'b0011111, // b
        7'b1001110, // C
        7'b0111101, // d
        7'b1001111, // E
        7'b1000111  // F
    };

    function automatic logic [15:0] nibble_to_onehot(input logic [3:0] n);
        logic [15:0] r;
        r = 16'd1 << n;
        return r;
    endfunction

    // Non-one-hot input (zero or several bits) decodes to a dark digit.
    function automatic logic [6:0] onehot_to_seg(input logic [15:0] oh);
        logic [6:0] s;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) s = s | SEG_TABLE[i];
        end
        if (oh == '0 || (oh & (oh - 16'd1)) != '0) s = '0;
        return s;
    endfunction

endpackage

// File: rtl/hex_display_scanner_timer.sv
// digit_slot_timer: per-digit slot counter 0..REFRESH_DIV-1.
// in_blank reports whether the coming cycle falls in the blank window.
module digit_slot_timer
    import hex_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic slot_end,
    output logic in_blank
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at the slot end, zero while cleared.
    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        slot_end = (cnt_q == CW'(REFRESH_DIV - 1));
        if (slot_end || clear) cnt_d = '0;
        in_blank = (cnt_d < CW'(BLANK_CYCLES));
    end

    // Slot counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed hex display scanner with double-buffered value input.
// Define LZ_BLANK_EN to blank leading-zero digits.
module hex_display_scanner
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_an,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    scan_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          boundary;
    logic          clear;
    logic          slot_end;
    logic          in_blank;

    logic [VW-1:0] shadow_q, pend_val_q;
    logic          pend_full_q, pend_full_d;
    logic          ready_q;
    logic          capture;
    logic          load;

    logic [3:0]            nib;
    logic [NUM_DIGITS-1:0] sel;
    logic                  show;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fd_q;

    assign clear = !enable || (state_q == IDLE);

    digit_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .slot_end (slot_end),
        .in_blank (in_blank)
    );

    // Scan FSM next state, digit index and frame boundary detect.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        boundary = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = '0;
                end
                BLANK: begin
                    if (!in_blank) state_d = SHOW;
                end
                SHOW: begin
                    if (slot_end) begin
                        state_d = BLANK;
                        if (idx_q == LAST) begin
                            idx_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state and digit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign capture = value_valid && ready_q;
    assign load    = pend_full_q && (boundary || state_q == IDLE);

    // Pending slot fills on capture and drains into shadow.
    always_comb begin
        pend_full_d = pend_full_q;
        if (capture)   pend_full_d = 1'b1;
        else if (load) pend_full_d = 1'b0;
    end

    // Pending and shadow value buffers plus ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val_q  <= '0;
            pend_full_q <= 1'b0;
            shadow_q    <= '0;
            ready_q     <= 1'b1;
        end else begin
            if (capture) pend_val_q <= value_in;
            if (load)    shadow_q   <= pend_val_q;
            pend_full_q <= pend_full_d;
            ready_q     <= !pend_full_d;
        end
    end

    // Select the active nibble and its anode bit.
    always_comb begin
        nib = '0;
        sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib    = shadow_q[4*i +: 4];
                sel[i] = 1'b1;
            end
        end
    end

`ifdef LZ_BLANK_EN
    logic [IW-1:0] lz_top;

    // Highest non-zero nibble; digit 0 is always shown.
    always_comb begin
        lz_top = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (shadow_q[4*i +: 4] != 4'h0) lz_top = IW'(i);
        end
        show = (idx_q <= lz_top);
    end
`else
    assign show = 1'b1;
`endif

    // Segment and anode drive for the current SHOW slot.
    always_comb begin
        seg_d = '0;
        an_d  = '0;
        if (state_q == SHOW && enable && show) begin
            seg_d = onehot_to_seg(nibble_to_onehot(nib));
            an_d  = sel;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            an_q  <= '0;
            fd_q  <= 1'b0;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
            fd_q  <= boundary;
        end
    end

    assign seg         = seg_q;
    assign dig_an      = an_q;
    assign frame_done  = fd_q;
    assign value_ready = ready_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized bench for hex_display_scanner against a slot-arithmetic model.
// Parameters: 4 digits, 8-cycle slots, 2 blank cycles.
module tb_hex_display_scanner;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FR = ND * RD;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [15:0]   value_in;
    logic          value_valid;
    logic          value_ready;
    logic [6:0]    seg;
    logic [ND-1:0] dig_an;
    logic          frame_done;

    int n_vec;
    int n_err;

    bit          m_scan;
    int          m_p;
    logic [15:0] m_shadow;
    bit          m_pend;
    logic [15:0] m_pval;
    logic [6:0]  m_seg;
    logic [3:0]  m_an;
    bit          m_fd;
    bit          m_rdy;

    hex_display_scanner #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .value_in    (value_in),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .seg         (seg),
        .dig_an      (dig_an),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h want %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1111110;
            4'h1: hex7 = 7'b0110000;
            4'h2: hex7 = 7'b1101101;
            4'h3: hex7 = 7'b1111001;
            4'h4: hex7 = 7'b0110011;
            4'h5: hex7 = 7'b1011011;
            4'h6: hex7 = 7'b1011111;
            4'h7: hex7 = 7'b1110000;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1111011;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b0011111;
            4'hC: hex7 = 7'b1001110;
            4'hD: hex7 = 7'b0111101;
            4'hE: hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    // Whether digit d is lit given the displayed value.
    function automatic bit lit(input int d, input logic [15:0] v);
`ifdef LZ_BLANK_EN
        int top;
        top = 0;
        for (int i = 1; i < ND; i++)
            if (((v >> (4 * i)) & 16'hF) != 0) top = i;
        lit = (d <= top);
`else
        lit = (d >= 0) && (v === v);
`endif
    endfunction

    task automatic model_reset();
        m_scan   = 0;
        m_p      = 0;
        m_shadow = '0;
        m_pend   = 0;
        m_pval   = '0;
        m_seg    = '0;
        m_an     = '0;
        m_fd     = 0;
        m_rdy    = 1;
    endtask

    // Advance the model across one rising edge.
    task automatic model_edge(input bit en, input bit vld,
                              input logic [15:0] val);
        bit cap;
        bit bnd;
        bit ld;
        int d;
        int off;
        cap = vld && !m_pend;
        bnd = m_scan && en && (m_p % FR == FR - 1);
        ld  = m_pend && (bnd || !m_scan);
        off = m_p % RD;
        d   = (m_p / RD) % ND;
        m_seg = '0;
        m_an  = '0;
        if (m_scan && en && off >= BC && lit(d, m_shadow)) begin
            m_seg = hex7(4'((m_shadow >> (4 * d)) & 16'hF));
            m_an  = 4'(1 << d);
        end
        m_fd = bnd;
        if (ld) m_shadow = m_pval;
        if (cap) begin
            m_pend = 1;
            m_pval = val;
        end else if (ld) begin
            m_pend = 0;
        end
        m_rdy = !m_pend;
        if (!en) begin
            m_scan = 0;
            m_p    = 0;
        end else if (!m_scan) begin
            m_scan = 1;
            m_p    = 0;
        end else begin
            m_p = m_p + 1;
        end
    endtask

    task automatic check_outs();
        chk("seg", 32'(seg), 32'(m_seg));
        chk("dig_an", 32'(dig_an), 32'(m_an));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("value_ready", 32'(value_ready), 32'(m_rdy));
    endtask

    // Drive one cycle of inputs at the negedge, check at the next one.
    task automatic step(input bit en, input bit vld,
                        input logic [15:0] val);
        enable      = en;
        value_valid = vld;
        value_in    = val;
        model_edge(en, vld, val);
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 16'h0);
    endtask

    // Run until the model phase hits target within one frame.
    task automatic run_to(input int target);
        int k;
        k = 0;
        while ((!m_scan || m_p % FR != target) && k < 2 * FR) begin
            step(1, 0, 16'h0);
            k++;
        end
        chk("run_to", 32'(k < 2 * FR), 32'd1);
    endtask

    task automatic rst_pulse();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_seg", 32'(seg), 32'd0);
        chk("rst_an", 32'(dig_an), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_rdy", 32'(value_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int burst;
        int off_left;
        bit en_r;
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        enable      = 1'b0;
        value_valid = 1'b0;
        value_in    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outs();
        rst_n = 1'b1;

        idle_run(3 * FR);

        run_to(13);
        step(1, 1, 16'h3A7F);
        idle_run(3 * FR);

        for (int i = 0; i < 6; i++) step(1, 1, 16'($urandom));
        idle_run(2 * FR);

        run_to(20);
        for (int i = 0; i < 4; i++) step(0, 1, 16'hBEEF);
        step(0, 0, 16'h0);
        idle_run(2 * FR);

        run_to(19);
        rst_pulse();
        idle_run(2 * FR);

        step(1, 1, 16'h0050);
        idle_run(3 * FR);
        step(1, 1, 16'h0000);
        idle_run(3 * FR);
        step(1, 1, 16'h0C00);
        idle_run(2 * FR);

        burst    = 0;
        off_left = 0;
        for (int i = 0; i < 2500; i++) begin
            if (off_left > 0) begin
                off_left--;
                en_r = 0;
            end else if ($urandom_range(0, 149) == 0) begin
                off_left = $urandom_range(1, 20);
                en_r = 0;
            end else begin
                en_r = 1;
            end
            if (burst == 0 && $urandom_range(0, 14) == 0)
                burst = $urandom_range(1, 12);
            if (burst > 0) begin
                burst--;
                step(en_r, 1, 16'($urandom));
            end else begin
                step(en_r, 0, 16'($urandom));
            end
            if (i == 1234) rst_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
